// File: rtl/ifu.sv
// ifu -- instruction fetch unit.
// Issues sequential word-aligned fetch addresses to instruction memory.
// Buffers in-order responses with their PCs in a small FIFO.
// Presents the FIFO head to the EXU under valid/ready.
// Applies taken/offset redirects by flushing the FIFO and re-steering fetch.
// Optional build macro: IFU_BYPASS_EN. When defined, a response arriving while
// the buffer is empty and nothing is being dropped goes straight to the EXU in
// the same cycle.
module ifu #(
  parameter int unsigned    AW         = 32,
  parameter int unsigned    DW         = 32,
  parameter int unsigned    FIFO_DEPTH = 4,
  parameter int unsigned    MAX_OS     = 2,
  parameter logic [AW-1:0]  RST_PC     = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          ifu2mem_req_vld,
  input  logic          ifu2mem_req_rdy,
  output logic [AW-1:0] ifu2mem_req_addr,
  input  logic          mem2ifu_rsp_vld,
  input  logic [DW-1:0] mem2ifu_rsp_data,
  output logic          ifu2exu_req_vld,
  input  logic          ifu2exu_req_rdy,
  output logic [DW-1:0] ifu2exu_req_ir,
  output logic [AW-1:0] ifu2exu_req_pc,
  input  logic          exu2ifu_taken,
  input  logic [DW-1:0] exu2ifu_offset
);

  // Pointer width into the buffer.
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Counter width, with one spare bit so fifo_cnt + os_cnt cannot overflow.
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;

  logic          r_run;
  logic [AW-1:0] r_fpc;
  logic [AW-1:0] r_rpc;
  logic [CW-1:0] r_os_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_fifo_cnt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_fifo_ir [FIFO_DEPTH];
  logic [AW-1:0] r_fifo_pc [FIFO_DEPTH];

  logic          w_fifo_empty;
  logic [CW-1:0] w_occ;
  logic          w_req_hs;
  logic          w_rsp_keep;
  logic          w_rsp_drop;
  logic          w_byp;
  logic          w_xfer;
  logic          w_redirect;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_target;
  logic [CW-1:0] w_os_nxt;

  assign w_fifo_empty = (r_fifo_cnt == '0);

  // Committed buffer slots: entries held plus responses still to be kept.
  assign w_occ = r_fifo_cnt + r_os_cnt - r_drop_cnt;

  // Request is combinational from registered state only.
  // r_run holds the request low while in reset.
  assign ifu2mem_req_vld  = r_run && (r_os_cnt < CW'(MAX_OS)) && (w_occ < CW'(FIFO_DEPTH));
  assign ifu2mem_req_addr = r_fpc;
  assign w_req_hs         = ifu2mem_req_vld && ifu2mem_req_rdy;

  assign w_rsp_keep = mem2ifu_rsp_vld && (r_drop_cnt == '0);
  assign w_rsp_drop = mem2ifu_rsp_vld && (r_drop_cnt != '0);

`ifdef IFU_BYPASS_EN
  assign w_byp = r_run && w_fifo_empty && w_rsp_keep;
`else
  assign w_byp = 1'b0;
`endif

  // EXU presentation: the FIFO head, or the live response when bypassing.
  assign ifu2exu_req_vld = !w_fifo_empty || w_byp;
  assign ifu2exu_req_ir  = w_byp ? mem2ifu_rsp_data : r_fifo_ir[r_rd_ptr];
  assign ifu2exu_req_pc  = w_byp ? r_rpc : r_fifo_pc[r_rd_ptr];

  assign w_xfer     = ifu2exu_req_vld && ifu2exu_req_rdy;
  assign w_redirect = w_xfer && exu2ifu_taken;
  assign w_pop      = w_xfer && !w_byp;
  assign w_push     = w_rsp_keep && !(w_byp && w_xfer);

  // Redirect target: the transferred PC plus offset, forced to a word address.
  assign w_sum    = ifu2exu_req_pc + exu2ifu_offset[AW-1:0];
  assign w_target = {w_sum[AW-1:2], 2'b00};

  // Outstanding requests after this cycle. A same-cycle handshake counts;
  // a same-cycle response does not, since it has already completed.
  assign w_os_nxt = r_os_cnt + CW'(w_req_hs) - CW'(mem2ifu_rsp_vld);

  // Run flag: enables fetching from the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Fetch PC, response PC, outstanding and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc      <= RST_PC;
      r_rpc      <= RST_PC;
      r_os_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_os_cnt <= w_os_nxt;
      if (w_redirect) begin
        r_fpc      <= w_target;
        r_rpc      <= w_target;
        r_drop_cnt <= w_os_nxt;
      end else begin
        if (w_req_hs) begin
          r_fpc <= r_fpc + AW'(4);
        end
        if (w_rsp_keep) begin
          r_rpc <= r_rpc + AW'(4);
        end
        if (w_rsp_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
      end
    end
  end

  // Instruction buffer pointers and occupancy; a redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (w_redirect) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Instruction buffer storage.
  // Cleared on reset so the EXU-side ir/pc outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_ir[i] <= '0;
        r_fifo_pc[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_ir[r_wr_ptr] <= mem2ifu_rsp_data;
      r_fifo_pc[r_wr_ptr] <= r_rpc;
    end
  end

`ifndef SYNTHESIS
  // The request rule reserves a slot for every kept response.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_fifo_cnt == CW'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu -- randomized self-checking bench for ifu.
// Model: architectural instruction stream.
// Each EXU transfer must carry the expected PC and the memory word at that PC.
// The next expected PC is PC+4, or the word-aligned target on a taken transfer.
module tb_ifu;

  localparam int unsigned  FIFO_DEPTH = 4;
  localparam int unsigned  MAX_OS     = 2;
  localparam logic [31:0]  RST_PC     = 32'h0;
  localparam logic [31:0]  WRAP_PC    = 32'hFFFF_FFF8;
`ifdef IFU_BYPASS_EN
  localparam int           FIRST_LAT  = 2;
`else
  localparam int           FIRST_LAT  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_vld, req_rdy = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_vld = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        x_vld, x_rdy = 1'b0;
  logic [31:0] x_ir, x_pc;
  logic        x_taken = 1'b0;
  logic [31:0] x_off = '0;

  logic        w_req_vld;
  logic        w_req_rdy = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_vld = 1'b0;
  logic [31:0] w_rsp_data = 32'h13;
  logic        w_x_vld;
  logic        w_x_rdy = 1'b1;
  logic [31:0] w_x_ir, w_x_pc;
  logic        w_x_taken = 1'b0;
  logic [31:0] w_x_off = '0;

  ifu #(.AW(32), .DW(32), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OS(MAX_OS), .RST_PC(RST_PC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifu2mem_req_vld(req_vld), .ifu2mem_req_rdy(req_rdy), .ifu2mem_req_addr(req_addr),
    .mem2ifu_rsp_vld(rsp_vld), .mem2ifu_rsp_data(rsp_data),
    .ifu2exu_req_vld(x_vld), .ifu2exu_req_rdy(x_rdy), .ifu2exu_req_ir(x_ir), .ifu2exu_req_pc(x_pc),
    .exu2ifu_taken(x_taken), .exu2ifu_offset(x_off));

  ifu #(.AW(32), .DW(32), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OS(MAX_OS), .RST_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .ifu2mem_req_vld(w_req_vld), .ifu2mem_req_rdy(w_req_rdy), .ifu2mem_req_addr(w_req_addr),
    .mem2ifu_rsp_vld(w_rsp_vld), .mem2ifu_rsp_data(w_rsp_data),
    .ifu2exu_req_vld(w_x_vld), .ifu2exu_req_rdy(w_x_rdy), .ifu2exu_req_ir(w_x_ir), .ifu2exu_req_pc(w_x_pc),
    .exu2ifu_taken(w_x_taken), .exu2ifu_offset(w_x_off));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------- instruction memory model ----------------
  typedef struct {
    logic [31:0] addr;
    longint      due;
  } mreq_t;

  mreq_t  pend[$];
  longint cyc = 0;
  longint last_due = 0;
  int     hs_cnt = 0;
  int     mem_lat_max = 1;
  int     mem_rdy_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  // In-order responder with random latency >= 1 and random request acceptance.
  always @(negedge clk) begin
    longint due;
    if (!rst_n) begin
      pend.delete();
      rsp_vld  = 1'b0;
      req_rdy  = 1'b0;
      hs_cnt   = 0;
      last_due = 0;
    end else begin
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        rsp_vld  = 1'b1;
        rsp_data = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        rsp_vld  = 1'b0;
        rsp_data = $urandom;
      end
      req_rdy = (int'($urandom_range(99)) < mem_rdy_pct);
      #2;
      if (rst_n && req_vld && req_rdy) begin
        chk("req_addr_align", 64'(req_addr[1:0]), 64'd0);
        due = cyc + longint'($urandom_range(mem_lat_max, 1));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{req_addr, due});
        hs_cnt++;
        chk("max_outstanding", 64'(pend.size() <= int'(MAX_OS)), 64'd1);
      end
    end
  end

  // ---------------- wrap instance: latency-1 memory, always-ready EXU ----------------
  logic        w_pend = 1'b0;
  logic [31:0] w_addrs [3];
  logic [31:0] w_pcs [3];
  logic [31:0] w_ir0 = '0;
  int          w_addr_n = 0;
  int          w_pc_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      w_rsp_vld = 1'b0;
      w_pend    = 1'b0;
    end else begin
      w_rsp_vld = w_pend;
      #2;
      w_pend = rst_n && w_req_vld;
      if (rst_n && w_req_vld && w_addr_n < 3) begin
        w_addrs[w_addr_n] = w_req_addr;
        w_addr_n++;
      end
      if (rst_n && w_x_vld && w_pc_n < 3) begin
        if (w_pc_n == 0) w_ir0 = w_x_ir;
        w_pcs[w_pc_n] = w_x_pc;
        w_pc_n++;
      end
    end
  end

  // ---------------- EXU side model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] off;
  } take_t;

  take_t       tk_q[$];
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] redir_tgt = '0;
  logic        redir_chk = 1'b0;
  int          n_xfer = 0;

  // One EXU cycle.
  // Optionally takes a redirect: a directed one when tk_q is non-empty,
  // otherwise a random one.
  task automatic exu_cycle(input int rdy_pct, input int take_pct);
    logic [31:0] off;
    logic        tk;
    logic        xfer;
    int          s;
    @(negedge clk);
    #1;
    if (redir_chk) begin
      chk("redir_next_addr", 64'(req_addr), 64'(redir_tgt));
      chk("redir_vld_gap", 64'(x_vld), 64'd0);
      redir_chk = 1'b0;
    end
    s     = int'($urandom_range(255)) - 128;
    off   = ($urandom_range(9) == 0) ? $urandom : 32'(s);
    tk    = (int'($urandom_range(99)) < take_pct);
    x_rdy = (int'($urandom_range(99)) < rdy_pct);
    if (tk_q.size() != 0) begin
      tk = 1'b0;
      if (x_vld && x_pc == tk_q[0].pc) begin
        tk    = 1'b1;
        off   = tk_q[0].off;
        x_rdy = 1'b1;
      end
    end
    xfer    = x_vld && x_rdy;
    x_taken = xfer ? tk : 1'($urandom_range(1));
    x_off   = off;
    #1;
    if (xfer) begin
      n_xfer++;
      chk("exu_pc", 64'(x_pc), 64'(exp_pc));
      chk("exu_ir", 64'(x_ir), 64'(mem_word(exp_pc)));
      if (tk) begin
        exp_pc    = (exp_pc + off) & 32'hFFFF_FFFC;
        redir_tgt = exp_pc;
        redir_chk = 1'b1;
        if (tk_q.size() != 0) void'(tk_q.pop_front());
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  // Reset is applied and released mid-cycle; release makes the next clock cycle 1.
  task automatic do_reset();
    @(negedge clk);
    #3;
    x_rdy   = 1'b0;
    x_taken = 1'b0;
    x_off   = '0;
    rst_n   = 1'b0;
    #1;
    chk("rst_req_vld", 64'(req_vld), 64'd0);
    chk("rst_req_addr", 64'(req_addr), 64'(RST_PC));
    chk("rst_exu_vld", 64'(x_vld), 64'd0);
    chk("rst_exu_ir", 64'(x_ir), 64'd0);
    chk("rst_exu_pc", 64'(x_pc), 64'd0);
    repeat (2) @(negedge clk);
    #3;
    rst_n     = 1'b1;
    exp_pc    = RST_PC;
    redir_chk = 1'b0;
    tk_q.delete();
  endtask

  initial begin
    int base;

    // Reset state, then back-to-back fetch with latency-1 memory and ready EXU.
    mem_lat_max = 1;
    mem_rdy_pct = 100;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      exu_cycle(100, 0);
      if (k <= 4) begin
        chk("seq_req_vld", 64'(req_vld), 64'd1);
        chk("seq_req_addr", 64'(req_addr), 64'(32'(4 * (k - 1))));
      end
      chk("first_lat_vld", 64'(x_vld), 64'(k >= FIRST_LAT));
    end
    repeat (10) exu_cycle(100, 0);

    // EXU stalled: fetching stops once the buffer is committed; drain in order.
    mem_lat_max = 3;
    do_reset();
    repeat (20) exu_cycle(0, 0);
    #1;
    chk("stall_hs_cnt", 64'(hs_cnt), 64'(FIFO_DEPTH));
    chk("stall_req_vld", 64'(req_vld), 64'd0);
    chk("stall_exu_vld", 64'(x_vld), 64'd1);
    repeat (4) exu_cycle(100, 0);
    chk("stall_drain_count", 64'(exp_pc), 64'(RST_PC + 32'h10));

    // Redirect at pc 0x8 by +0x10 with requests in flight.
    do_reset();
    tk_q.push_back('{32'h8, 32'h10});
    for (int i = 0; i < 200 && tk_q.size() != 0; i++) exu_cycle(100, 0);
    chk("redir_taken", 64'(tk_q.size()), 64'd0);
    base = n_xfer;
    for (int i = 0; i < 50 && n_xfer == base; i++) exu_cycle(100, 0);
    chk("redir_resumed", 64'(n_xfer > base), 64'd1);

    // Negative offset, then a misaligned offset whose low bits are cleared.
    mem_lat_max = 4;
    mem_rdy_pct = 70;
    tk_q.push_back('{32'h20, 32'hFFFF_FFF0});
    tk_q.push_back('{32'h20, 32'h3});
    for (int i = 0; i < 400 && tk_q.size() != 0; i++) exu_cycle(80, 0);
    chk("neg_off_taken", 64'(tk_q.size()), 64'd0);
    repeat (10) exu_cycle(80, 0);

    // Fetch and response PC wrap on the second instance.
    chk("wrap_addr0", 64'(w_addrs[0]), 64'(32'hFFFF_FFF8));
    chk("wrap_addr1", 64'(w_addrs[1]), 64'(32'hFFFF_FFFC));
    chk("wrap_addr2", 64'(w_addrs[2]), 64'(32'h0));
    chk("wrap_pc0", 64'(w_pcs[0]), 64'(32'hFFFF_FFF8));
    chk("wrap_pc1", 64'(w_pcs[1]), 64'(32'hFFFF_FFFC));
    chk("wrap_pc2", 64'(w_pcs[2]), 64'(32'h0));
    chk("wrap_ir0", 64'(w_ir0), 64'(32'h13));

    // Randomized traffic with random redirects and backpressure.
    base = n_xfer;
    repeat (3000) exu_cycle(70, 8);
    chk("random_progress", 64'((n_xfer - base) > 300), 64'd1);

    // Asynchronous reset pulse with a full buffer and taken asserted.
    mem_lat_max = 2;
    mem_rdy_pct = 100;
    repeat (20) exu_cycle(0, 0);
    chk("pulse_pre_vld", 64'(x_vld), 64'd1);
    @(negedge clk);
    x_taken = 1'b1;
    x_rdy   = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("pulse_exu_vld", 64'(x_vld), 64'd0);
    chk("pulse_req_vld", 64'(req_vld), 64'd0);
    chk("pulse_req_addr", 64'(req_addr), 64'(RST_PC));
    chk("pulse_exu_pc", 64'(x_pc), 64'd0);
    repeat (2) @(negedge clk);
    #3;
    rst_n     = 1'b1;
    exp_pc    = RST_PC;
    redir_chk = 1'b0;
    base      = n_xfer;
    exu_cycle(100, 0);
    chk("pulse_restart_addr", 64'(req_addr), 64'(RST_PC));
    repeat (12) exu_cycle(100, 0);
    chk("pulse_restart_progress", 64'((n_xfer - base) >= 4), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: the requesting end of the IFU→EXU instruction handshake. It generates sequential fetch addresses, issues them to instruction memory, and buffers returned words with their PCs in a small FIFO. It presents the FIFO head to the EXU under valid/ready and applies the EXU's taken/offset redirect by flushing and re-steering the fetch PC. It sits between the instruction memory port and `exu`.

## Interface
- `AW`, 32, address width
- `DW`, 32, instruction/data width; `DW >= AW` required
- `FIFO_DEPTH`, 4, instruction buffer entries (power of two, ≥2)
- `MAX_OS`, 2, maximum outstanding memory requests (≤ FIFO_DEPTH)
- `RST_PC`, 32'h0, fetch PC after reset (word aligned)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `ifu2mem_req_vld` out 1: fetch request valid
- `ifu2mem_req_rdy` in 1: memory accepts request
- `ifu2mem_req_addr` out AW: fetch address, word aligned
- `mem2ifu_rsp_vld` in 1: read data valid; in order, always accepted, earliest 1 cycle after request handshake
- `mem2ifu_rsp_data` in DW: instruction word
- `ifu2exu_req_vld` out 1: instruction valid to EXU
- `ifu2exu_req_rdy` in 1: EXU accepts
- `ifu2exu_req_ir` out DW: instruction
- `ifu2exu_req_pc` out AW: PC of instruction
- `exu2ifu_taken` in 1: redirect; sampled only in an EXU transfer cycle
- `exu2ifu_offset` in DW: two's-complement offset relative to transferred PC

## Operation
- State: `fpc` (next fetch address), `rpc` (PC of next kept response), `os_cnt` (outstanding requests), `drop_cnt` (responses to discard), FIFO of {ir, pc}.
- Request: `ifu2mem_req_vld = (os_cnt < MAX_OS) && (fifo_cnt + os_cnt - drop_cnt < FIFO_DEPTH)`; `addr = fpc`. On handshake: `fpc += 4` (wraps mod 2^AW), `os_cnt++`.
- Response: `os_cnt--`. If `drop_cnt != 0`: discard and decrement `drop_cnt`. Otherwise push {data, rpc} and increment `rpc` by 4. Space is guaranteed by the request rule, so overflow is impossible; assert in simulation.
- EXU side: `ifu2exu_req_vld = !fifo_empty`; ir/pc come from the FIFO head. A transfer (vld & rdy) pops the head.
- Redirect, when transfer & `exu2ifu_taken`:
  - `target = (head_pc + offset[AW-1:0])` mod 2^AW, with bits [1:0] cleared.
  - Next cycle: `fpc = rpc = target`; the FIFO is emptied, including any same-cycle push.
  - `drop_cnt = os_cnt_next`, which counts a same-cycle request handshake and excludes a same-cycle response, which is already discarded.
- `exu2ifu_taken` outside a transfer cycle is ignored.
- Simultaneous push and pop are allowed, so the FIFO count is unchanged; in the full case the pop frees the slot the same cycle.

## Timing
- Reset values: `ifu2mem_req_vld` 0 while in reset, `ifu2mem_req_addr` RST_PC, `ifu2exu_req_vld` 0, `ifu2exu_req_ir` 0, `ifu2exu_req_pc` 0; all counters 0, FIFO empty.
- The first request is asserted in the first cycle after `rst_n` deasserts.
- Request handshake in cycle N with response in N+k (k≥1): the entry is pushed at the end of N+k and `ifu2exu_req_vld` rises in N+k+1.
- A redirect in cycle R puts the new address on `ifu2mem_req_addr` in R+1; `ifu2exu_req_vld` is 0 in R+1.
- All outputs are registered except `ifu2mem_req_vld`, which is combinational from registered state, and the bypass path below.
- Asynchronous reset mid-operation: all state clears immediately. In-flight memory responses after reset are the memory's responsibility; the memory is reset together with this block.

## Configuration
- `IFU_BYPASS_EN` defined:
  - When the FIFO is empty, `drop_cnt == 0` and `mem2ifu_rsp_vld` is high, the response drives `ifu2exu_req_vld/ir/pc` combinationally in the same cycle (pc = rpc).
  - If transferred, it is not pushed; otherwise it is pushed normally.
  - A bypassed transfer may redirect in the same cycle.
  - Latency becomes N+k.
- Undefined: no combinational path from memory to EXU; latency N+k+1.

## Test plan
- Reset release with memory latency 1 and EXU always ready: addresses 0x0, 0x4, 0x8… are issued back-to-back; the EXU receives pc 0x0 with its ir in cycle 3 (cycle 2 with bypass), then one instruction per cycle.
- EXU rdy held 0: the IFU stops requesting once FIFO_DEPTH=4 entries plus outstanding fill; no entry is lost or overwritten. Releasing rdy delivers PCs 0x0–0xC in order.
- Transfer of pc 0x8 with taken=1, offset 0x10 while 2 requests are outstanding: next request addr 0x18; both stale responses are dropped; the next EXU pc is 0x18.
- Negative offset: pc 0x20 taken with offset 0xFFFFFFF0 → next fetch and EXU pc 0x10; offset 0x3 → target 0x20 (low bits cleared).
- fpc wrap: RST_PC 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- `rst_n` pulsed low with a full FIFO and taken asserted: `ifu2exu_req_vld` drops immediately; after release, fetch restarts at RST_PC.
